pin_auth_ctrl: RTL and testbench

//  Card/PIN authentication front-end of the ATM datapath, directly upstream of the balance/withdraw stage.

---
 rtl/atm_pkg.sv | 22 ++
 rtl/atm_countdown.sv | 48 ++++
 rtl/pin_auth_ctrl.sv | 139 +++++++++++++
 tb/tb_pin_auth_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM card/PIN authentication front-end:
// FSM state encoding, datapath widths and a small attempt-counter helper.
package atm_pkg;

  localparam int TEMPO_W = 9;
  localparam int PIN_W   = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_WAIT_PIN = 3'd1;
  localparam state_t S_CHECK    = 3'd2;
  localparam state_t S_AUTH     = 3'd3;
  localparam state_t S_EJ_TRIES = 3'd4;
  localparam state_t S_EJ_TIME  = 3'd5;

  // Remaining-attempt decrement that holds at zero instead of wrapping.
  function automatic logic [1:0] tries_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/atm_countdown.sv
// Session countdown: tick prescaler plus a 9-bit down-counter that saturates
// at zero. A load restarts the prescaler so every reload gets a full tick.
module atm_countdown
  import atm_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [TEMPO_W-1:0] load_val,
  output logic [TEMPO_W-1:0] tempo,
  output logic               zero
);

  localparam int                PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0]   PS_ONE  = PS_W'(1);
  localparam logic [TEMPO_W-1:0] T_ONE  = TEMPO_W'(1);

  logic [PS_W-1:0]    prescale_r;
  logic [TEMPO_W-1:0] tempo_r;
  logic               tick_s;

  assign tick_s = run && (prescale_r == PS_LAST);
  assign tempo  = tempo_r;
  assign zero   = (tempo_r == {TEMPO_W{1'b0}});

  // Prescaler and saturating down-counter; load takes priority over run.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_r <= {PS_W{1'b0}};
      tempo_r    <= {TEMPO_W{1'b0}};
    end else if (load) begin
      prescale_r <= {PS_W{1'b0}};
      tempo_r    <= load_val;
    end else if (run) begin
      prescale_r <= tick_s ? {PS_W{1'b0}} : prescale_r + PS_ONE;
      if (tick_s && !zero) begin
        tempo_r <= tempo_r - T_ONE;
      end
    end else begin
      prescale_r <= {PS_W{1'b0}};
    end
  end

endmodule

// File: rtl/pin_auth_ctrl.sv
// Card/PIN authentication controller: session FSM, attempt counter and
// registered status outputs feeding the balance/withdraw stage.
module pin_auth_ctrl
  import atm_pkg::*;
#(
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 300,
  parameter int TICK_DIV  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               card_in,
  input  logic [PIN_W-1:0]   pin,
  input  logic               pin_valid,
  input  logic [PIN_W-1:0]   acct_pin,
  input  logic               activity,
  output logic               auth_ok,
  output logic               pin_match,
  output logic               eject_tries,
  output logic               eject_timeout,
  output logic [1:0]         tries_left,
  output logic [TEMPO_W-1:0] tempo
);

  localparam logic [1:0]         TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [TEMPO_W-1:0] TEMPO_INIT = TEMPO_W'(TIMEOUT);

  state_t             state_r, next_state_s;
  logic [PIN_W-1:0]   pin_r;
  logic [1:0]         tries_r;
  logic               match_s;
  logic               cd_load_s, cd_run_s, cd_zero_s;
  logic [TEMPO_W-1:0] cd_val_s;
  logic               auth_ok_s, pin_match_s, eject_tries_s, eject_timeout_s;

  assign match_s    = (pin_r == acct_pin);
  assign tries_left = tries_r;

  atm_countdown #(.TICK_DIV(TICK_DIV)) u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (cd_load_s),
    .run      (cd_run_s),
    .load_val (cd_val_s),
    .tempo    (tempo),
    .zero     (cd_zero_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; card removal outranks every other transition.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:     next_state_s = card_in ? S_WAIT_PIN : S_IDLE;
      S_WAIT_PIN: begin
        if (!card_in)        next_state_s = S_IDLE;
        else if (pin_valid)  next_state_s = S_CHECK;
        else if (cd_zero_s)  next_state_s = S_EJ_TIME;
        else                 next_state_s = S_WAIT_PIN;
      end
      S_CHECK: begin
        if (!card_in)              next_state_s = S_IDLE;
        else if (match_s)          next_state_s = S_AUTH;
        else if (tries_r > 2'd1)   next_state_s = S_WAIT_PIN;
        else                       next_state_s = S_EJ_TRIES;
      end
      S_AUTH: begin
        if (!card_in)        next_state_s = S_IDLE;
        else if (activity)   next_state_s = S_AUTH;
        else if (cd_zero_s)  next_state_s = S_EJ_TIME;
        else                 next_state_s = S_AUTH;
      end
      S_EJ_TRIES: next_state_s = card_in ? S_EJ_TRIES : S_IDLE;
      S_EJ_TIME:  next_state_s = card_in ? S_EJ_TIME  : S_IDLE;
      default:    next_state_s = S_IDLE;
    endcase
  end

  // Output and countdown control decode from current and next state.
  always_comb begin
    auth_ok_s       = (next_state_s == S_AUTH);
    eject_tries_s   = (next_state_s == S_EJ_TRIES);
    eject_timeout_s = (next_state_s == S_EJ_TIME);
    pin_match_s     = (state_r == S_WAIT_PIN) && (next_state_s == S_CHECK) && (pin == acct_pin);
    cd_run_s        = 1'b0;
    cd_load_s       = 1'b0;
    cd_val_s        = TEMPO_INIT;
    if (state_r != S_IDLE && next_state_s == S_IDLE) begin
      // Leaving a session clears the display.
      cd_load_s = 1'b1;
      cd_val_s  = {TEMPO_W{1'b0}};
    end else if (state_r == S_IDLE) begin
      cd_load_s = card_in;
    end else if (state_r == S_CHECK) begin
      cd_load_s = (next_state_s == S_AUTH) || (next_state_s == S_WAIT_PIN);
    end else if (state_r == S_AUTH) begin
      cd_load_s = activity;
      cd_run_s  = !activity;
    end else if (state_r == S_WAIT_PIN) begin
      cd_run_s  = 1'b1;
    end else begin
      cd_run_s  = 1'b0;
    end
  end

  // Registered outputs, captured PIN and attempt counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      auth_ok       <= 1'b0;
      pin_match     <= 1'b0;
      eject_tries   <= 1'b0;
      eject_timeout <= 1'b0;
      pin_r         <= {PIN_W{1'b0}};
      tries_r       <= TRIES_INIT;
    end else begin
      auth_ok       <= auth_ok_s;
      pin_match     <= pin_match_s;
      eject_tries   <= eject_tries_s;
      eject_timeout <= eject_timeout_s;
      if (state_r == S_WAIT_PIN && pin_valid) begin
        pin_r <= pin;
      end
      if (state_r == S_IDLE || next_state_s == S_IDLE) begin
        tries_r <= TRIES_INIT;
      end else if (state_r == S_CHECK && !match_s) begin
        tries_r <= tries_dec(tries_r);
      end
    end
  end

endmodule

// File: tb/tb_pin_auth_ctrl.sv
// Self-checking bench for pin_auth_ctrl: a default-parameter instance and a
// short-timeout instance share stimulus; pin_match expectations flow through a queue.
module tb_pin_auth_ctrl;

  logic       clk = 1'b0;
  logic       rst, card_in, pin_valid, activity;
  logic [3:0] pin, acct_pin;

  logic       auth_ok, pin_match, eject_tries, eject_timeout;
  logic [1:0] tries_left;
  logic [8:0] tempo;
  logic       auth_ok_t, pin_match_t, eject_tries_t, eject_timeout_t;
  logic [1:0] tries_left_t;
  logic [8:0] tempo_t;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned which;
    logic        match;
  } exp_t;
  exp_t sb[$];

  pin_auth_ctrl dut (
    .clk(clk), .rst(rst), .card_in(card_in), .pin(pin), .pin_valid(pin_valid),
    .acct_pin(acct_pin), .activity(activity), .auth_ok(auth_ok), .pin_match(pin_match),
    .eject_tries(eject_tries), .eject_timeout(eject_timeout), .tries_left(tries_left), .tempo(tempo)
  );

  pin_auth_ctrl #(.MAX_TRIES(3), .TIMEOUT(20), .TICK_DIV(1)) dut_t (
    .clk(clk), .rst(rst), .card_in(card_in), .pin(pin), .pin_valid(pin_valid),
    .acct_pin(acct_pin), .activity(activity), .auth_ok(auth_ok_t), .pin_match(pin_match_t),
    .eject_tries(eject_tries_t), .eject_timeout(eject_timeout_t), .tries_left(tries_left_t), .tempo(tempo_t)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pin(input logic [3:0] p, input int unsigned which, input bit live);
    exp_t e;
    pin       = p;
    pin_valid = 1'b1;
    e.which   = which;
    e.match   = live && (p == acct_pin);
    sb.push_back(e);
  endtask

  task automatic check_match();
    exp_t e;
    logic got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e   = sb.pop_front();
      got = (e.which == 0) ? pin_match : pin_match_t;
      if (got !== e.match) begin errors++; $display("FAIL pin_match(dut%0d): got %b exp %b", e.which, got, e.match); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; card_in = 1'b0; pin_valid = 1'b0; activity = 1'b0; pin = 4'h0; acct_pin = 4'hA;
    tick(); tick();
    checks++; if (auth_ok !== 1'b0) begin errors++; $display("FAIL reset auth_ok: got %b exp 0", auth_ok); end
    checks++; if (pin_match !== 1'b0) begin errors++; $display("FAIL reset pin_match: got %b exp 0", pin_match); end
    checks++; if ({eject_tries, eject_timeout} !== 2'b00) begin errors++; $display("FAIL reset ejects: got %b exp 00", {eject_tries, eject_timeout}); end
    checks++; if (tries_left !== 2'd3) begin errors++; $display("FAIL reset tries_left: got %0d exp 3", tries_left); end
    checks++; if (tempo !== 9'd0) begin errors++; $display("FAIL reset tempo: got %0d exp 0", tempo); end
    checks++; if (tempo_t !== 9'd0) begin errors++; $display("FAIL reset tempo_t: got %0d exp 0", tempo_t); end
    rst = 1'b0;
  endtask

  task automatic test_correct_pin();
    card_in = 1'b1;
    tick();
    checks++; if (tempo !== 9'd300) begin errors++; $display("FAIL insert tempo: got %0d exp 300", tempo); end
    repeat (4) tick();
    checks++; if (tempo !== 9'd296) begin errors++; $display("FAIL wait tempo: got %0d exp 296", tempo); end
    drive_pin(4'hA, 0, 1'b1);
    tick();
    pin_valid = 1'b0;
    check_match();
    checks++; if (auth_ok !== 1'b0) begin errors++; $display("FAIL check auth_ok: got %b exp 0", auth_ok); end
    tick();
    checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL auth auth_ok: got %b exp 1", auth_ok); end
    checks++; if (tempo !== 9'd300) begin errors++; $display("FAIL auth tempo: got %0d exp 300", tempo); end
    checks++; if (pin_match !== 1'b0) begin errors++; $display("FAIL auth pin_match: got %b exp 0", pin_match); end
  endtask

  task automatic test_wrong_pins();
    card_in = 1'b0;
    tick();
    checks++; if (auth_ok !== 1'b0 || tempo !== 9'd0) begin errors++; $display("FAIL pull auth: auth_ok %b tempo %0d exp 0 0", auth_ok, tempo); end
    card_in = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_pin(4'h3, 0, 1'b1);
      tick();
      pin_valid = 1'b0;
      check_match();
      checks++; if (tempo !== 9'd299) begin errors++; $display("FAIL check tempo %0d: got %0d exp 299", i, tempo); end
      tick();
      checks++; if (tries_left !== 2'(2 - i)) begin errors++; $display("FAIL tries_left %0d: got %0d exp %0d", i, tries_left, 2 - i); end
      checks++; if (eject_tries !== (i == 2)) begin errors++; $display("FAIL eject_tries %0d: got %b exp %b", i, eject_tries, (i == 2)); end
      checks++; if (auth_ok !== 1'b0) begin errors++; $display("FAIL wrong auth_ok %0d: got %b exp 0", i, auth_ok); end
    end
    repeat (3) tick();
    checks++; if ({eject_tries, eject_timeout, tries_left} !== 4'b1000) begin errors++; $display("FAIL eject hold: got %b exp 1000", {eject_tries, eject_timeout, tries_left}); end
    card_in = 1'b0;
    tick();
    checks++; if (eject_tries !== 1'b0 || tries_left !== 2'd3) begin errors++; $display("FAIL eject release: eject %b tries %0d exp 0 3", eject_tries, tries_left); end
  endtask

  task automatic test_timeout();
    card_in = 1'b1;
    tick();
    checks++; if (tempo_t !== 9'd20) begin errors++; $display("FAIL t insert tempo: got %0d exp 20", tempo_t); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (tempo_t !== 9'(20 - k) || eject_timeout_t !== 1'b0) begin errors++; $display("FAIL countdown %0d: tempo %0d eject %b exp %0d 0", k, tempo_t, eject_timeout_t, 20 - k); end
    end
    tick();
    checks++; if (eject_timeout_t !== 1'b1 || eject_tries_t !== 1'b0) begin errors++; $display("FAIL timeout eject: got %b%b exp 10", eject_timeout_t, eject_tries_t); end
    checks++; if (auth_ok_t !== 1'b0 || tempo_t !== 9'd0) begin errors++; $display("FAIL timeout state: auth %b tempo %0d exp 0 0", auth_ok_t, tempo_t); end
    card_in = 1'b0;
    tick();
    checks++; if (eject_timeout_t !== 1'b0) begin errors++; $display("FAIL timeout release: got %b exp 0", eject_timeout_t); end
    card_in = 1'b1;
    tick();
    repeat (20) tick();
    checks++; if (tempo_t !== 9'd0) begin errors++; $display("FAIL expiry tempo: got %0d exp 0", tempo_t); end
    drive_pin(4'hA, 1, 1'b1);
    tick();
    pin_valid = 1'b0;
    check_match();
    checks++; if (eject_timeout_t !== 1'b0) begin errors++; $display("FAIL pin priority eject: got %b exp 0", eject_timeout_t); end
    tick();
    checks++; if (auth_ok_t !== 1'b1 || tempo_t !== 9'd20) begin errors++; $display("FAIL late auth: auth %b tempo %0d exp 1 20", auth_ok_t, tempo_t); end
  endtask

  task automatic test_auth_inactivity();
    repeat (15) tick();
    checks++; if (tempo_t !== 9'd5) begin errors++; $display("FAIL auth count: got %0d exp 5", tempo_t); end
    activity = 1'b1;
    tick();
    activity = 1'b0;
    checks++; if (tempo_t !== 9'd20 || auth_ok_t !== 1'b1) begin errors++; $display("FAIL activity reload: tempo %0d auth %b exp 20 1", tempo_t, auth_ok_t); end
    repeat (10) tick();
    drive_pin(4'h3, 1, 1'b0);
    tick();
    pin_valid = 1'b0;
    check_match();
    checks++; if (auth_ok_t !== 1'b1 || tempo_t !== 9'd9) begin errors++; $display("FAIL pin ignored: auth %b tempo %0d exp 1 9", auth_ok_t, tempo_t); end
    repeat (9) tick();
    checks++; if (tempo_t !== 9'd0 || auth_ok_t !== 1'b1) begin errors++; $display("FAIL auth at zero: tempo %0d auth %b exp 0 1", tempo_t, auth_ok_t); end
    activity = 1'b1;
    tick();
    activity = 1'b0;
    checks++; if (tempo_t !== 9'd20 || eject_timeout_t !== 1'b0) begin errors++; $display("FAIL activity priority: tempo %0d eject %b exp 20 0", tempo_t, eject_timeout_t); end
    repeat (20) tick();
    tick();
    checks++; if (eject_timeout_t !== 1'b1 || auth_ok_t !== 1'b0) begin errors++; $display("FAIL auth timeout: eject %b auth %b exp 1 0", eject_timeout_t, auth_ok_t); end
    card_in = 1'b0;
    tick();
  endtask

  task automatic test_card_pulled();
    card_in = 1'b1;
    tick();
    repeat (2) begin
      drive_pin(4'h3, 0, 1'b1);
      tick();
      pin_valid = 1'b0;
      check_match();
      tick();
    end
    checks++; if (tries_left !== 2'd1) begin errors++; $display("FAIL pre-pull tries: got %0d exp 1", tries_left); end
    card_in = 1'b0;
    tick();
    checks++; if ({auth_ok, pin_match, eject_tries, eject_timeout} !== 4'b0000) begin errors++; $display("FAIL pulled outputs: got %b exp 0000", {auth_ok, pin_match, eject_tries, eject_timeout}); end
    checks++; if (tries_left !== 2'd3 || tempo !== 9'd0) begin errors++; $display("FAIL pulled tries/tempo: got %0d %0d exp 3 0", tries_left, tempo); end
    card_in = 1'b1;
    tick();
    checks++; if (tempo !== 9'd300 || tries_left !== 2'd3) begin errors++; $display("FAIL reinsert: tempo %0d tries %0d exp 300 3", tempo, tries_left); end
    drive_pin(4'hA, 0, 1'b1);
    tick();
    pin_valid = 1'b0;
    check_match();
    tick();
    checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL reinsert auth: got %b exp 1", auth_ok); end
  endtask

  task automatic test_reset_in_auth();
    rst = 1'b1;
    tick();
    checks++; if (auth_ok !== 1'b0 || tempo !== 9'd0 || tries_left !== 2'd3) begin errors++; $display("FAIL mid reset: auth %b tempo %0d tries %0d exp 0 0 3", auth_ok, tempo, tries_left); end
    rst = 1'b0;
    tick();
    checks++; if (tempo !== 9'd300 || auth_ok !== 1'b0) begin errors++; $display("FAIL post reset: tempo %0d auth %b exp 300 0", tempo, auth_ok); end
  endtask

  initial begin
    test_reset();
    test_correct_pin();
    test_wrong_pins();
    test_timeout();
    test_auth_inactivity();
    test_card_pulled();
    test_reset_in_auth();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
